// File: rtl/xfcp_uart_autobaud.sv
// Auto-baud for the XFCP UART: times the 9-bit-time low pulse of 0x00 delimiters and drives prescale.
// Optional break-triggered re-training is compiled in with XFCP_AUTOBAUD_RELOCK_EN.
module xfcp_uart_autobaud #(
  parameter int          COUNT_WIDTH      = 24,
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd135,
  parameter int          MIN_IDLE         = 256,
  parameter int          MIN_PRESCALE     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  input  logic        enable,
  output logic [15:0] prescale,
  output logic        locked,
  output logic        measure_error
);

  localparam int W  = COUNT_WIDTH;
  localparam int IW = $clog2(MIN_IDLE + 1);
  localparam int DW = $clog2(W + 1);
  localparam logic [W-1:0]  CNT_MAX      = {W{1'b1}};
  localparam logic [W-1:0]  MIN_CNT      = W'(72 * MIN_PRESCALE);
  localparam logic [W-1:0]  PRESCALE_MAX = W'(17'h0FFFF);
  localparam logic [IW-1:0] IDLE_DONE    = IW'(MIN_IDLE);
  localparam logic [DW-1:0] DIV_LAST     = DW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_MEASURE, S_CHECK, S_DIVIDE, S_COMPARE, S_LOCKED
  } state_t;

  state_t         state_q, state_d;
  logic           rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [IW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [6:0]     rem_q, rem_d;
  logic [DW-1:0]  div_cnt_q, div_cnt_d;
  logic [W-1:0]   ref_q, ref_d;
  logic           ref_valid_q, ref_valid_d;
  logic [15:0]    prescale_q, prescale_d;
  logic           locked_q, locked_d;
  logic           measure_error_q, measure_error_d;

  logic           rxd_fall, rxd_rise, reject;
  logic [W:0]     dividend;
  logic [7:0]     trial, trial_sub;
  logic           trial_ge;
  logic [W-1:0]   q_diff;

  assign rxd_fall  = rxd_prev_q & ~rxd_s2_q;
  assign rxd_rise  = ~rxd_prev_q & rxd_s2_q;
  // +36 before dividing by 72 rounds the bit-time to the nearest prescale
  assign dividend  = {1'b0, cnt_q} + (W+1)'(36);
  assign trial     = {rem_q, dvd_q[W-1]};
  assign trial_ge  = (trial >= 8'd72);
  assign trial_sub = trial - 8'd72;
  assign q_diff    = (dvd_q >= ref_q) ? (dvd_q - ref_q) : (ref_q - dvd_q);

`ifdef XFCP_AUTOBAUD_RELOCK_EN
  logic [W:0] break_limit;
  assign break_limit = (W+1)'(prescale_q) * (W+1)'(144);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1_q        <= 1'b1;
      rxd_s2_q        <= 1'b1;
      rxd_prev_q      <= 1'b1;
      state_q         <= S_IDLE;
      idle_cnt_q      <= '0;
      cnt_q           <= '0;
      dvd_q           <= '0;
      rem_q           <= '0;
      div_cnt_q       <= '0;
      ref_q           <= '0;
      ref_valid_q     <= 1'b0;
      prescale_q      <= DEFAULT_PRESCALE;
      locked_q        <= 1'b0;
      measure_error_q <= 1'b0;
    end else begin
      rxd_s1_q        <= uart_rxd;
      rxd_s2_q        <= rxd_s1_q;
      rxd_prev_q      <= rxd_s2_q;
      state_q         <= state_d;
      idle_cnt_q      <= idle_cnt_d;
      cnt_q           <= cnt_d;
      dvd_q           <= dvd_d;
      rem_q           <= rem_d;
      div_cnt_q       <= div_cnt_d;
      ref_q           <= ref_d;
      ref_valid_q     <= ref_valid_d;
      prescale_q      <= prescale_d;
      locked_q        <= locked_d;
      measure_error_q <= measure_error_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idle_cnt_d      = '0;
    cnt_d           = cnt_q;
    dvd_d           = dvd_q;
    rem_d           = rem_q;
    div_cnt_d       = div_cnt_q;
    ref_d           = ref_q;
    ref_valid_d     = ref_valid_q;
    prescale_d      = prescale_q;
    locked_d        = locked_q;
    measure_error_d = 1'b0;
    reject          = 1'b0;

    // idle qualification restarts on every entry to IDLE and on any low cycle
    if (state_q == S_IDLE && rxd_s2_q)
      idle_cnt_d = (idle_cnt_q == IDLE_DONE) ? idle_cnt_q : idle_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (enable && idle_cnt_q == IDLE_DONE) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (rxd_fall) begin
          cnt_d   = '0;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (rxd_rise)              state_d = S_CHECK;
        else if (cnt_q == CNT_MAX) reject  = 1'b1;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      S_CHECK: begin
        if (cnt_q < MIN_CNT) begin
          reject = 1'b1;
        end else begin
          // dividend MSB preloads the remainder so W iterations cover W+1 bits
          rem_d     = {6'd0, dividend[W]};
          dvd_d     = dividend[W-1:0];
          div_cnt_d = '0;
          state_d   = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        rem_d     = trial_ge ? trial_sub[6:0] : trial[6:0];
        dvd_d     = {dvd_q[W-2:0], trial_ge};
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DIV_LAST) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (!ref_valid_q) begin
          ref_d       = dvd_q;
          ref_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (q_diff <= (ref_q >> 3)) begin
          prescale_d = (dvd_q > PRESCALE_MAX) ? 16'hFFFF : dvd_q[15:0];
          locked_d   = 1'b1;
          cnt_d      = '0;
          state_d    = S_LOCKED;
        end else begin
          ref_d           = dvd_q;
          measure_error_d = 1'b1;
          state_d         = S_IDLE;
        end
      end
      S_LOCKED: begin
`ifdef XFCP_AUTOBAUD_RELOCK_EN
        if (rxd_s2_q)              cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if ({1'b0, cnt_q} > break_limit) begin
          locked_d    = 1'b0;
          prescale_d  = DEFAULT_PRESCALE;
          ref_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (reject) begin
      measure_error_d = 1'b1;
      ref_valid_d     = 1'b0;
      state_d         = S_IDLE;
    end

    if (!enable) begin
      state_d         = S_IDLE;
      locked_d        = 1'b0;
      prescale_d      = DEFAULT_PRESCALE;
      ref_valid_d     = 1'b0;
      measure_error_d = 1'b0;
    end
  end

  assign prescale      = prescale_q;
  assign locked        = locked_q;
  assign measure_error = measure_error_q;

endmodule

// File: tb/tb_xfcp_uart_autobaud.sv
// Directed + randomized bench for xfcp_uart_autobaud against a pulse-level reference model.
module tb_xfcp_uart_autobaud;
  localparam int CW = 24;

  logic        clk = 1'b0;
  logic        rst, uart_rxd, enable;
  logic [15:0] prescale;
  logic        locked, measure_error;

  int errors = 0, checks = 0;
  int err_seen = 0, err_wide = 0;
  logic err_prev = 1'b0;
  int lat;

  // reference model state
  int m_ref = 0, m_prescale = 135, m_err = 0;
  bit m_valid = 0, m_locked = 0;

  xfcp_uart_autobaud #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .enable(enable),
    .prescale(prescale), .locked(locked), .measure_error(measure_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      err_seen <= 0; err_wide <= 0; err_prev <= 1'b0;
    end else begin
      if (measure_error) err_seen <= err_seen + 1;
      if (measure_error && err_prev) err_wide <= err_wide + 1;
      err_prev <= measure_error;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic void model_pulse(input int n);
    int q, d;
    if (m_locked) begin
`ifdef XFCP_AUTOBAUD_RELOCK_EN
      if (n > 144 * m_prescale) begin
        m_locked = 0; m_prescale = 135; m_valid = 0;
      end
`endif
      return;
    end
    if (n < 288) begin
      m_err++; m_valid = 0;
      return;
    end
    q = (n + 36) / 72;
    if (!m_valid) begin
      m_ref = q; m_valid = 1;
    end else begin
      d = (q > m_ref) ? q - m_ref : m_ref - q;
      if (d <= m_ref / 8) begin
        m_locked = 1; m_prescale = (q > 65535) ? 65535 : q;
      end else begin
        m_ref = q; m_err++;
      end
    end
  endfunction

  function automatic void model_disable();
    m_locked = 0; m_prescale = 135; m_valid = 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    @(posedge clk); #1;
    check({tag, "_locked"}, 32'(locked), 32'(m_locked));
    check({tag, "_prescale"}, 32'(prescale), 32'(m_prescale));
    check({tag, "_errcount"}, 32'(err_seen), 32'(m_err));
  endtask

  task automatic pulse(input int n, input int gap);
    @(posedge clk); #1 uart_rxd = 1'b0;
    repeat (n) @(posedge clk);
    #1 uart_rxd = 1'b1;
    model_pulse(n);
    repeat (gap) @(posedge clk);
  endtask

  task automatic disable_cycle(input string tag);
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    model_disable();
    check({tag, "_locked"}, 32'(locked), 32'(0));
    check({tag, "_prescale"}, 32'(prescale), 32'(135));
    repeat (300) @(posedge clk);
  endtask

  initial begin
    int p, p_prev, n;
    rst = 1'b1; enable = 1'b1; uart_rxd = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    check_state("reset");
    repeat (300) @(posedge clk);
    check_state("idle");

    // first lock at prescale 100, with latency from the second rising edge
    pulse(7200, 400);
    check_state("ref100");
    @(posedge clk); #1 uart_rxd = 1'b0;
    repeat (7200) @(posedge clk);
    #1 uart_rxd = 1'b1;
    lat = 0;
    while (locked !== 1'b1 && lat < 60) begin
      @(posedge clk); #1 lat++;
    end
    model_pulse(7200);
    check("lock_latency", 32'(lat), 32'(CW + 5));
    repeat (400) @(posedge clk);
    check_state("lock100");

    disable_cycle("enable_drop");
    pulse(7200, 400);
    check_state("relock_first");
    pulse(7200, 400);
    check_state("relock_second");

    // line break while locked
    pulse(15000, 400);
    check_state("break");
    disable_cycle("after_break");

    // inconsistent pair then a consistent third pulse
    pulse(7200, 400);
    pulse(9000, 400);
    check_state("mismatch");
    pulse(9000, 400);
    check_state("lock125");

    // glitch rejection and reference invalidation
    disable_cycle("pre_glitch");
    pulse(200, 400);
    check_state("glitch");
    pulse(432, 400);
    pulse(200, 400);
    pulse(432, 400);
    check_state("ref_invalidated");
    pulse(432, 400);
    check_state("lock6");

    p_prev = 8;
    for (int i = 0; i < 6; i++) begin
      if (m_locked) disable_cycle("rand_unlock");
      p = ($urandom_range(0, 1) == 0) ? p_prev : int'($urandom_range(5, 15));
      if ($urandom_range(0, 3) == 0) n = int'($urandom_range(10, 250));
      else n = 72 * p + int'($urandom_range(0, 40)) - 20;
      p_prev = p;
      pulse(n, 400);
      check_state("rand");
    end

    check("err_one_cycle", 32'(err_wide), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
